id_ex_stage: RTL

//  Decode->execute pipeline register fed by the register file's four operand outputs.

---
 rtl/id_ex_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with write-back bypass, load-use bubble insertion,
// back-pressure hold and branch flush. Define ID_EX_STALL_CNT_EN to add the E_stall_cnt counter.
module id_ex_stage #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5,
  parameter int OP_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 D_valid,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  input  logic [ADDR_SIZE-1:0] D_rd,
  input  logic                 D_we,
  input  logic                 D_ld,
  input  logic                 D_str,
  input  logic                 D_brn,
  input  logic [OP_W-1:0]      D_op,
  input  logic [XLEN-1:0]      D_a,
  input  logic [XLEN-1:0]      D_b,
  input  logic [XLEN-1:0]      D_a2,
  input  logic [XLEN-1:0]      D_b2,
  input  logic                 WB_we,
  input  logic [ADDR_SIZE-1:0] WB_rd,
  input  logic [XLEN-1:0]      WB_data_mem,
  input  logic                 E_ready,
  input  logic                 EX_flush,
  output logic                 D_stall,
  output logic                 E_valid,
  output logic [XLEN-1:0]      E_a,
  output logic [XLEN-1:0]      E_b,
  output logic [XLEN-1:0]      E_a2,
  output logic [XLEN-1:0]      E_b2,
  output logic [ADDR_SIZE-1:0] E_rd,
  output logic                 E_we,
  output logic                 E_ld,
  output logic                 E_str,
  output logic                 E_brn,
  output logic [OP_W-1:0]      E_op
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]          E_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 eValid_q, eValid_d;
  logic [XLEN-1:0]      eA_q, eA_d;
  logic [XLEN-1:0]      eB_q, eB_d;
  logic [XLEN-1:0]      eA2_q, eA2_d;
  logic [XLEN-1:0]      eB2_q, eB2_d;
  logic [ADDR_SIZE-1:0] eRd_q, eRd_d;
  logic                 eWe_q, eWe_d;
  logic                 eLd_q, eLd_d;
  logic                 eStr_q, eStr_d;
  logic                 eBrn_q, eBrn_d;
  logic [OP_W-1:0]      eOp_q, eOp_d;

  logic            bypA, bypB;
  logic [XLEN-1:0] aByp, bByp, a2Byp, b2Byp;
  logic            loadUse;

  // The regfile writes on the same edge we capture, so its read port cannot see WB data yet.
  // Branches keep the pc in D_a; loads/stores/branches keep the offset in D_b.
  assign bypA  = WB_we && (WB_rd != '0) && (WB_rd == D_ra);
  assign bypB  = WB_we && (WB_rd != '0) && (WB_rd == D_rb);
  assign a2Byp = bypA ? WB_data_mem : D_a2;
  assign b2Byp = bypB ? WB_data_mem : D_b2;
  assign aByp  = (bypA && !D_brn) ? WB_data_mem : D_a;
  assign bByp  = (bypB && !(D_ld || D_str || D_brn)) ? WB_data_mem : D_b;

  // A D_rb match counts even for stores, since store data travels on D_b2.
  assign loadUse = D_valid && eValid_q && eLd_q && eWe_q && (eRd_q != '0) &&
                   ((eRd_q == D_ra) || (eRd_q == D_rb));

  assign D_stall = !rst && (!E_ready || (!EX_flush && loadUse));

  always_comb begin
    eValid_d = eValid_q;
    eA_d     = eA_q;
    eB_d     = eB_q;
    eA2_d    = eA2_q;
    eB2_d    = eB2_q;
    eRd_d    = eRd_q;
    eWe_d    = eWe_q;
    eLd_d    = eLd_q;
    eStr_d   = eStr_q;
    eBrn_d   = eBrn_q;
    eOp_d    = eOp_q;
    if (E_ready) begin
      if (EX_flush || loadUse) begin
        eValid_d = 1'b0;
      end else begin
        eValid_d = D_valid;
        eA_d     = aByp;
        eB_d     = bByp;
        eA2_d    = a2Byp;
        eB2_d    = b2Byp;
        eRd_d    = D_rd;
        eWe_d    = D_we;
        eLd_d    = D_ld;
        eStr_d   = D_str;
        eBrn_d   = D_brn;
        eOp_d    = D_op;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!E_ready) begin
          state_d = HOLD;
        end else if (loadUse && !EX_flush) begin
          state_d = BUBBLE;
        end
      end
      HOLD: begin
        if (E_ready) begin
          state_d = RUN;
        end
      end
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      eValid_q <= 1'b0;
      eA_q     <= '0;
      eB_q     <= '0;
      eA2_q    <= '0;
      eB2_q    <= '0;
      eRd_q    <= '0;
      eWe_q    <= 1'b0;
      eLd_q    <= 1'b0;
      eStr_q   <= 1'b0;
      eBrn_q   <= 1'b0;
      eOp_q    <= '0;
    end else begin
      state_q  <= state_d;
      eValid_q <= eValid_d;
      eA_q     <= eA_d;
      eB_q     <= eB_d;
      eA2_q    <= eA2_d;
      eB2_q    <= eB2_d;
      eRd_q    <= eRd_d;
      eWe_q    <= eWe_d;
      eLd_q    <= eLd_d;
      eStr_q   <= eStr_d;
      eBrn_q   <= eBrn_d;
      eOp_q    <= eOp_d;
    end
  end

  assign E_valid = eValid_q;
  assign E_a     = eA_q;
  assign E_b     = eB_q;
  assign E_a2    = eA2_q;
  assign E_b2    = eB2_q;
  assign E_rd    = eRd_q;
  assign E_we    = eWe_q;
  assign E_ld    = eLd_q;
  assign E_str   = eStr_q;
  assign E_brn   = eBrn_q;
  assign E_op    = eOp_q;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stallCnt_q, stallCnt_d;

  assign stallCnt_d = D_stall ? stallCnt_q + 32'd1 : stallCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign E_stall_cnt = stallCnt_q;
`endif

endmodule
